// File: rtl/keypad_lock_ctrl_if.sv
// Keypad-to-lock-controller bundle: one-cycle key pulses in, Moore lock/LED status out.
// Keypad side is master; the controller binds the slave modport.
interface keypad_lock_ctrl_if #(
  parameter int DIGIT_W  = 2,
  parameter int MAX_FAIL = 3
);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  logic               key_valid;
  logic [DIGIT_W-1:0] key_val;
  logic               key_star;
  logic               lock;
  logic               open;
  logic               led_red;
  logic               led_green;
  logic               alarm;
  logic [FAIL_W-1:0]  fail_cnt;

  modport master (
    output key_valid, key_val, key_star,
    input  lock, open, led_red, led_green, alarm, fail_cnt
  );

  modport slave (
    input  key_valid, key_val, key_star,
    output lock, open, led_red, led_green, alarm, fail_cnt
  );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// Door-lock FSM: enrol a CODE_LEN-digit code in OPEN, unlock with code+'*', timed lockout after MAX_FAIL misses.
// Moore outputs react one cycle after a key pulse; no backpressure. Optional AUTO_RELOCK_EN adds idle relock.
module keypad_lock_ctrl #(
  parameter int DIGIT_W     = 2,
  parameter int CODE_LEN    = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter int RELOCK_CYC  = 5000
) (
  input logic                clk,
  input logic                n_rst,
  keypad_lock_ctrl_if.slave  kif
);

  localparam int ENTRY_W = CODE_LEN * DIGIT_W;
  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int TMR_W   = $clog2(LOCKOUT_CYC + 1);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CODE_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(LOCKOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_OPEN,
    ST_LOCKED,
    ST_LOCKOUT
  } state_t;

  state_t              state_q, state_d;
  logic [ENTRY_W-1:0]  code_q, code_d;
  logic [ENTRY_W-1:0]  entry_q, entry_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;

  logic [ENTRY_W+DIGIT_W-1:0] entry_cat;
  logic [ENTRY_W-1:0]         entry_shift;

`ifdef AUTO_RELOCK_EN
  localparam int IDLE_W = $clog2(RELOCK_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RELOCK_CYC - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              code_valid_q, code_valid_d;
`endif

  // First key lands in the most significant digit; the oldest digit falls off the top.
  assign entry_cat   = {entry_q, kif.key_val};
  assign entry_shift = entry_cat[ENTRY_W-1:0];

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    tmr_d   = tmr_q;
`ifdef AUTO_RELOCK_EN
    idle_d       = '0;
    code_valid_d = code_valid_q;
`endif

    case (state_q)
      ST_OPEN: begin
        // '*' wins over a simultaneous digit, which is dropped.
        if (kif.key_star) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (kif.key_valid) begin
          if (cnt_q == CNT_LAST) begin
            code_d  = entry_shift;
            entry_d = '0;
            cnt_d   = '0;
            state_d = ST_LOCKED;
`ifdef AUTO_RELOCK_EN
            code_valid_d = 1'b1;
`endif
          end else begin
            entry_d = entry_shift;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
`ifdef AUTO_RELOCK_EN
        // Relock only makes sense once a code exists, so idle time after reset is ignored.
        if (!kif.key_star && !kif.key_valid && code_valid_q) begin
          if (idle_q == IDLE_LAST) begin
            state_d = ST_LOCKED;
            entry_d = '0;
            cnt_d   = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
`endif
      end

      ST_LOCKED: begin
        if (kif.key_star) begin
          entry_d = '0;
          cnt_d   = '0;
          if (cnt_q == CNT_FULL && entry_q == code_q) begin
            state_d = ST_OPEN;
            fail_d  = '0;
          end else if (fail_q == FAIL_LAST) begin
            fail_d  = FAIL_MAX;
            state_d = ST_LOCKOUT;
            tmr_d   = TMR_LOAD;
          end else begin
            fail_d = fail_q + FAIL_W'(1);
          end
        end else if (kif.key_valid && cnt_q != CNT_FULL) begin
          entry_d = entry_shift;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      ST_LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      default: state_d = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_OPEN;
      code_q  <= '0;
      entry_q <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      tmr_q   <= '0;
`ifdef AUTO_RELOCK_EN
      idle_q       <= '0;
      code_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
`ifdef AUTO_RELOCK_EN
      idle_q       <= idle_d;
      code_valid_q <= code_valid_d;
`endif
    end
  end

  assign kif.open      = (state_q == ST_OPEN);
  assign kif.lock      = (state_q != ST_OPEN);
  assign kif.led_red   = (state_q != ST_LOCKED);
  assign kif.led_green = (state_q == ST_LOCKED);
  assign kif.alarm     = (state_q == ST_LOCKOUT);
  assign kif.fail_cnt  = fail_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Randomised and directed bench for keypad_lock_ctrl against a digit-queue reference model.
// Honours AUTO_RELOCK_EN the same way the design does.
module tb_keypad_lock_ctrl;

  localparam int DIGIT_W     = 2;
  localparam int CODE_LEN    = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 16;
  localparam int RELOCK_CYC  = 8;

  logic clk = 1'b0;
  logic n_rst;

  keypad_lock_ctrl_if #(.DIGIT_W(DIGIT_W), .MAX_FAIL(MAX_FAIL)) kif ();

  keypad_lock_ctrl #(
    .DIGIT_W    (DIGIT_W),
    .CODE_LEN   (CODE_LEN),
    .MAX_FAIL   (MAX_FAIL),
    .LOCKOUT_CYC(LOCKOUT_CYC),
    .RELOCK_CYC (RELOCK_CYC)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .kif  (kif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 = door open, 1 = locked, 2 = lockout.
  int m_mode;
  int m_code[$];
  int m_entry[$];
  int m_fails;
  int m_left;
  int m_idle;
  bit m_armed;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit entry_matches();
    if (m_entry.size() != CODE_LEN || m_code.size() != CODE_LEN) return 1'b0;
    for (int i = 0; i < CODE_LEN; i++)
      if (m_entry[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(input bit v, input int d, input bit s, input bit r);
    if (!r) begin
      m_mode = 0;
      m_code.delete();
      m_entry.delete();
      m_fails = 0;
      m_left  = 0;
      m_idle  = 0;
      m_armed = 1'b0;
      return;
    end
    case (m_mode)
      0: begin
        if (s) m_entry.delete();
        else if (v) begin
          m_entry.push_back(d);
          if (m_entry.size() == CODE_LEN) begin
            m_code = m_entry;
            m_entry.delete();
            m_mode  = 1;
            m_armed = 1'b1;
          end
        end
`ifdef AUTO_RELOCK_EN
        if (m_mode == 0) begin
          if (s || v) m_idle = 0;
          else if (m_armed) begin
            m_idle++;
            if (m_idle == RELOCK_CYC) begin
              m_mode = 1;
              m_entry.delete();
              m_idle = 0;
            end
          end
        end
`endif
      end
      1: begin
        if (s) begin
          if (entry_matches()) begin
            m_mode  = 0;
            m_fails = 0;
            m_idle  = 0;
          end else begin
            m_fails++;
            if (m_fails == MAX_FAIL) begin
              m_mode = 2;
              m_left = LOCKOUT_CYC;
            end
          end
          m_entry.delete();
        end else if (v && m_entry.size() < CODE_LEN) begin
          m_entry.push_back(d);
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode  = 1;
          m_fails = 0;
        end
      end
    endcase
  endfunction

  task automatic check_outputs();
    chk("open",      kif.open,      (m_mode == 0));
    chk("lock",      kif.lock,      (m_mode != 0));
    chk("led_red",   kif.led_red,   (m_mode != 1));
    chk("led_green", kif.led_green, (m_mode == 1));
    chk("alarm",     kif.alarm,     (m_mode == 2));
    chk("fail_cnt",  kif.fail_cnt,  m_fails);
  endtask

  // Drive at the falling edge, update the model on the rising edge, check at the next falling edge.
  task automatic step(input bit v, input int d, input bit s, input bit r);
    kif.key_valid = v;
    kif.key_val   = d[DIGIT_W-1:0];
    kif.key_star  = s;
    n_rst         = r;
    @(posedge clk);
    model_step(v, d, s, r);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic key(input int d);    step(1'b1, d, 1'b0, 1'b1); endtask
  task automatic star();              step(1'b0, 0, 1'b1, 1'b1); endtask
  task automatic idle(input int n);   for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b1); endtask
  task automatic do_reset();          step(1'b0, 0, 1'b0, 1'b0); endtask

  task automatic keys4(input int a, input int b, input int c, input int e);
    key(a); key(b); key(c); key(e);
  endtask

  int alarm_cyc;

  initial begin
    kif.key_valid = 1'b0;
    kif.key_val   = '0;
    kif.key_star  = 1'b0;
    n_rst         = 1'b0;

    // Reset state and enrolment.
    do_reset();
    chk("rst_open",  kif.open, 1);
    chk("rst_fails", kif.fail_cnt, 0);
    keys4(1, 2, 3, 0);
    chk("enrol_lock",  kif.lock, 1);
    chk("enrol_green", kif.led_green, 1);

    // Correct code opens.
    keys4(1, 2, 3, 0); star();
    chk("unlock_open", kif.open, 1);
    chk("unlock_red",  kif.led_red, 1);

    // Three misses -> lockout of exactly LOCKOUT_CYC cycles, keys ignored inside it.
    keys4(1, 2, 3, 0);
    keys4(1, 2, 3, 1); star();
    chk("miss1", kif.fail_cnt, 1);
    keys4(1, 2, 3, 1); star();
    chk("miss2", kif.fail_cnt, 2);
    keys4(1, 2, 3, 1);
    alarm_cyc = 0;
    star();
    if (kif.alarm) alarm_cyc++;
    for (int i = 0; i < 20; i++) begin
      if (i < LOCKOUT_CYC - 1) step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), 1'b1);
      else idle(1);
      if (kif.alarm) alarm_cyc++;
    end
    chk("lockout_len", alarm_cyc, LOCKOUT_CYC);
    chk("post_lockout_fails", kif.fail_cnt, 0);
    keys4(1, 2, 3, 0); star();
    chk("post_lockout_open", kif.open, 1);

    // Short entry, extra digit, and digit colliding with '*'.
    keys4(1, 2, 3, 0);
    key(1); key(2); key(3); star();
    chk("short_entry", kif.fail_cnt, 1);
    keys4(1, 2, 3, 0); key(2); star();
    chk("extra_digit_open", kif.open, 1);
    keys4(1, 2, 3, 0);
    key(1); key(2); key(3); step(1'b1, 0, 1'b1, 1'b1);
    chk("collide_fail", kif.fail_cnt, 1);

    // Reset mid-entry and mid-lockout; old code forgotten.
    key(1); key(2); do_reset();
    chk("rst_mid_entry", kif.open, 1);
    keys4(1, 2, 3, 0);
    for (int i = 0; i < MAX_FAIL; i++) begin key(3); star(); end
    idle(4);
    do_reset();
    chk("rst_mid_lockout_alarm", kif.alarm, 0);
    chk("rst_mid_lockout_fails", kif.fail_cnt, 0);
    keys4(0, 0, 0, 1);
    keys4(1, 2, 3, 0); star();
    chk("old_code_rejected", kif.open, 0);
    keys4(0, 0, 0, 1); star();
    chk("new_code_open", kif.open, 1);

`ifdef AUTO_RELOCK_EN
    keys4(1, 2, 3, 0);
    keys4(1, 2, 3, 0); star();
    idle(RELOCK_CYC);
    chk("relock", kif.lock, 1);
    keys4(1, 2, 3, 0); star();
    chk("relock_code_kept", kif.open, 1);
    do_reset();
    idle(3 * RELOCK_CYC);
    chk("no_relock_unenrolled", kif.open, 1);
`endif

    // Random traffic, biased toward the enrolled code so unlocks actually happen.
    for (int n = 0; n < 2500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) do_reset();
      else if (r < 40) key($urandom_range(0, 3));
      else if (r < 50) star();
      else if (r < 53) step(1'b1, $urandom_range(0, 3), 1'b1, 1'b1);
      else if (r < 63) begin
        if (m_code.size() == CODE_LEN && m_mode == 1) begin
          int c[$];
          c = m_code;
          for (int i = 0; i < CODE_LEN; i++) key(c[i]);
          star();
        end else begin
          key($urandom_range(0, 3));
        end
      end else if (r < 66) idle(RELOCK_CYC + 2);
      else idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
